// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 36x36 multiplier requester:
// leaf width default, FSM state type and the partial-product shift helper.
package mult_pkg;

  localparam int unsigned LEAF_W_DEFAULT = 18;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    ISSUE,
    RELEASE,
    FINISH
  } mreq_state_t;

  // idx order: lo*lo, lo*hi, hi*lo, hi*hi
  function automatic int unsigned pp_shift(input logic [1:0] idx, input int unsigned leaf_w);
    case (idx)
      2'd0:    return 0;
      2'd3:    return 2 * leaf_w;
      default: return leaf_w;
    endcase
  endfunction

endpackage

// File: rtl/pp_accum.sv
// Partial-product accumulator: clears on job start, adds the leaf result
// shifted according to the partial-product index.
module pp_accum
  import mult_pkg::*;
#(
  parameter int unsigned LEAF_W = LEAF_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  add_i,
  input  logic [2*LEAF_W-1:0]   leaf_p_i,
  input  logic [1:0]            idx_i,
  output logic [4*LEAF_W-1:0]   acc_o
);

  localparam int unsigned PW = 4 * LEAF_W;

  logic [PW-1:0] acc_q, acc_d, addend;

  always_comb begin
    addend = PW'(leaf_p_i) << pp_shift(idx_i, LEAF_W);
    acc_d  = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + addend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mult36_seq_requester.sv
// Sequential 2L x 2L unsigned multiplier built from four passes through one
// external L x L leaf, exposing the same level start/done protocol upstream.
module mult36_seq_requester
  import mult_pkg::*;
#(
  parameter int unsigned LEAF_W = LEAF_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2*LEAF_W-1:0]   A,
  input  logic [2*LEAF_W-1:0]   B,
  output logic                  done,
  output logic [4*LEAF_W-1:0]   P,
  output logic                  leaf_start,
  output logic [LEAF_W-1:0]     leaf_a,
  output logic [LEAF_W-1:0]     leaf_b,
  input  logic                  leaf_done,
  input  logic [2*LEAF_W-1:0]   leaf_p
);

  localparam int unsigned W  = 2 * LEAF_W;
  localparam int unsigned PW = 2 * W;

  mreq_state_t   state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]    idx_q, idx_d;
  logic          done_q, done_d;
  logic [PW-1:0] p_q, p_d;
  logic          acc_clr, acc_add;
  logic [PW-1:0] acc;

  pp_accum #(.LEAF_W(LEAF_W)) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (acc_clr),
    .add_i    (acc_add),
    .leaf_p_i (leaf_p),
    .idx_i    (idx_q),
    .acc_o    (acc)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    done_d  = done_q;
    p_d     = p_q;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          idx_d   = '0;
          acc_clr = 1'b1;
          state_d = SYNC;
        end
      end
      // Drain a leaf still reporting done from before a reset or abort.
      SYNC: begin
        if (!leaf_done) state_d = ISSUE;
      end
      ISSUE: begin
        if (leaf_done) begin
          acc_add = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!leaf_done) begin
          if (idx_q == 2'd3) begin
            // The last add landed on the ISSUE->RELEASE edge, so acc is final.
            p_d     = acc;
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ISSUE;
          end
        end
      end
      FINISH: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      p_q     <= p_d;
    end
  end

  assign leaf_start = (state_q == ISSUE);
  assign leaf_a     = idx_q[1] ? a_q[W-1:LEAF_W] : a_q[LEAF_W-1:0];
  assign leaf_b     = idx_q[0] ? b_q[W-1:LEAF_W] : b_q[LEAF_W-1:0];
  assign done       = done_q;
  assign P          = p_q;

endmodule

// File: tb/tb_mult36_seq_requester.sv
// Directed bench for mult36_seq_requester with a behavioural 18x18 leaf,
// a product scoreboard and a leaf handshake monitor.
module tb_mult36_seq_requester;

  localparam int unsigned L  = 18;
  localparam int unsigned W  = 2 * L;
  localparam int unsigned PW = 2 * W;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  A     = '0;
  logic [W-1:0]  B     = '0;
  logic          done;
  logic [PW-1:0] P;
  logic          leaf_start;
  logic [L-1:0]  leaf_a, leaf_b;
  logic          leaf_done = 1'b0;
  logic [W-1:0]  leaf_p    = '0;

  int total = 0;
  int bad   = 0;
  int leaf_delay = 1;
  int leaf_cnt   = 0;
  logic [PW-1:0] sb[$];
  logic [PW-1:0] last_exp = '0;

  int           ls_rises = 0;
  int           viol     = 0;
  int           stab     = 0;
  logic         prev_ls  = 1'b0;
  logic [L-1:0] pa = '0, pb = '0;

  always #5 clk = ~clk;

  mult36_seq_requester #(.LEAF_W(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .done       (done),
    .P          (P),
    .leaf_start (leaf_start),
    .leaf_a     (leaf_a),
    .leaf_b     (leaf_b),
    .leaf_done  (leaf_done),
    .leaf_p     (leaf_p)
  );

  // Leaf: not reset by rst_n, so it can be left high by an aborted job.
  always @(posedge clk) begin
    if (!leaf_start) begin
      leaf_done <= 1'b0;
      leaf_cnt  <= 0;
    end else if (!leaf_done) begin
      if (leaf_cnt + 1 >= leaf_delay) begin
        leaf_done <= 1'b1;
        leaf_p    <= W'(leaf_a) * W'(leaf_b);
      end else begin
        leaf_cnt <= leaf_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (leaf_start && !prev_ls) begin
      ls_rises <= ls_rises + 1;
      if (leaf_done) viol <= viol + 1;
    end
    if (leaf_start && prev_ls && (leaf_a !== pa || leaf_b !== pb)) stab <= stab + 1;
    prev_ls <= leaf_start;
    pa      <= leaf_a;
    pb      <= leaf_b;
  end

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a job at the negedge; returns just after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    sb.push_back(PW'(a) * PW'(b));
    @(posedge clk);
  endtask

  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done && edges < budget);
    check("done_seen", done, 1);
  endtask

  task automatic pop_check(input string tag);
    logic [PW-1:0] e;
    if (sb.size() == 0) e = ~P;
    else e = sb.pop_front();
    last_exp = e;
    check(tag, P, e);
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("done_fall", done, 0);
  endtask

  initial begin
    int e;
    int r0;
    int n;

    #1 rst_n = 1'b0;
    #15;
    check("rst_done", done, 0);
    check("rst_P", P, 0);
    check("rst_leaf_start", leaf_start, 0);
    check("rst_leaf_a", leaf_a, 0);
    check("rst_leaf_b", leaf_b, 0);
    @(negedge clk) rst_n = 1'b1;

    // Small product, latency and pulse count, then start held after done.
    r0 = ls_rises;
    issue(36'h0_0000_0003, 36'h0_0000_0005);
    wait_done(100, e);
    check("t1_latency", e, 17);
    pop_check("t1_P");
    for (int unsigned i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("t4_done_hold", done, 1);
    end
    @(negedge clk);
    #1;
    check("t1_leaf_pulses", ls_rises - r0, 4);
    release_start();
    check("t4_P_hold", P, last_exp);
    check("t4_leaf_idle", leaf_start, 0);

    // Full-scale operands.
    issue(36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF);
    wait_done(100, e);
    pop_check("t2_P");
    release_start();

    // Only the hi*hi term; start dropped and operands changed after acceptance.
    issue(36'h1_0000_0000, 36'h2_0000_0000);
    @(negedge clk);
    start = 1'b0;
    A = 36'hA_BCDE_F012;
    B = 36'h3_3333_3333;
    wait_done(100, e);
    pop_check("t3_P");
    @(posedge clk);
    #1;
    check("t3_done_pulse", done, 0);

    // Reset while idx=2 is in ISSUE with the leaf reporting done.
    r0 = ls_rises;
    issue(36'h1_2345_6789, 36'h0_0000_0777);
    n = 0;
    while (!((ls_rises - r0) >= 3 && leaf_done && leaf_start) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_reached_idx2", leaf_start && leaf_done, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_done", done, 0);
    check("t5_rst_P", P, 0);
    check("t5_rst_leaf_start", leaf_start, 0);
    check("t5_rst_leaf_a", leaf_a, 0);
    check("t5_rst_leaf_b", leaf_b, 0);
    void'(sb.pop_back());
    A = 36'd7;
    B = 36'd9;
    sb.push_back(PW'(7) * PW'(9));
    #1 rst_n = 1'b1;
    @(posedge clk);
    wait_done(100, e);
    check("t5_latency", e, 17);
    pop_check("t5_P");
    release_start();

    // Slow leaf.
    @(negedge clk) leaf_delay = 5;
    issue(36'h1_2345_6789, 36'h9_8765_4321);
    wait_done(400, e);
    pop_check("t6_P");
    release_start();

    @(negedge clk);
    #1;
    check("leaf_rise_while_done", viol, 0);
    check("leaf_operand_stability", stab, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
